// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: byte FIFO feeding an 8N1/parity/2-stop serializer; tx_o falls one edge after
// a write into an idle, empty block; wr_ack_o drops while the FIFO is full and the producer retries.
module uart_tx_fifo #(
  parameter int CLK_DIV    = 868,
  parameter int FIFO_DEPTH = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                        clk_i,
  input  logic                        arst_n_i,
  input  logic                        wr_req_i,
  input  logic [7:0]                  wr_data_i,
  output logic                        wr_ack_o,
  output logic                        tx_o,
  output logic                        busy_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_cnt_o
);

  localparam int              AW          = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]     DEPTH_C     = (AW + 1)'(FIFO_DEPTH);
  localparam logic [15:0]     BAUD_RELOAD = 16'(CLK_DIV - 1);
  localparam logic            ODD_PAR     = (PARITY == 2);
  localparam logic            HAS_PAR     = (PARITY != 0);
  localparam logic            TWO_STOP    = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_cnt;

  state_t        r_state;
  logic [15:0]   r_baud;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shreg;
  logic          r_par;
  logic          r_stop_idx;
  logic          r_tx;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_bit_end;
  logic          w_last_stop;
  logic [7:0]    w_head;

  assign w_full      = (r_cnt == DEPTH_C);
  assign w_empty     = (r_cnt == '0);
  assign w_push      = wr_req_i && !w_full;
  assign w_bit_end   = (r_baud == 16'd0);
  assign w_last_stop = !TWO_STOP || r_stop_idx;
  assign w_head      = r_mem[r_rptr];

  // The pop decision is shared by the FIFO and the FSM so both always agree on it.
  assign w_pop = !w_empty &&
                 ((r_state == S_IDLE) ||
                  ((r_state == S_STOP) && w_bit_end && w_last_stop));

  assign wr_ack_o   = !w_full;
  assign tx_o       = r_tx;
  assign busy_o     = (r_state != S_IDLE) || !w_empty;
  assign fifo_cnt_o = r_cnt;

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wptr] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_cnt <= r_cnt + 1'b1;
      end else if (w_pop && !w_push) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_state    <= S_IDLE;
      r_baud     <= '0;
      r_bit_idx  <= '0;
      r_shreg    <= '0;
      r_par      <= 1'b0;
      r_stop_idx <= 1'b0;
      r_tx       <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
          if (w_pop) begin
            r_shreg <= w_head;
            r_par   <= ^w_head;
            r_baud  <= BAUD_RELOAD;
            r_tx    <= 1'b0;
            r_state <= S_START;
          end
        end

        S_START: begin
          if (w_bit_end) begin
            r_baud    <= BAUD_RELOAD;
            r_bit_idx <= 3'd0;
            r_tx      <= r_shreg[0];
            r_state   <= S_DATA;
          end else begin
            r_baud <= r_baud - 16'd1;
          end
        end

        S_DATA: begin
          if (w_bit_end) begin
            r_baud <= BAUD_RELOAD;
            if (r_bit_idx == 3'd7) begin
              if (HAS_PAR) begin
                r_tx    <= r_par ^ ODD_PAR;
                r_state <= S_PAR;
              end else begin
                r_tx       <= 1'b1;
                r_stop_idx <= 1'b0;
                r_state    <= S_STOP;
              end
            end else begin
              r_shreg   <= r_shreg >> 1;
              r_tx      <= r_shreg[1];
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end else begin
            r_baud <= r_baud - 16'd1;
          end
        end

        S_PAR: begin
          if (w_bit_end) begin
            r_baud     <= BAUD_RELOAD;
            r_tx       <= 1'b1;
            r_stop_idx <= 1'b0;
            r_state    <= S_STOP;
          end else begin
            r_baud <= r_baud - 16'd1;
          end
        end

        S_STOP: begin
          if (w_bit_end) begin
            r_baud <= BAUD_RELOAD;
            if (!w_last_stop) begin
              r_stop_idx <= 1'b1;
            end else if (w_pop) begin
              // Chain straight into the next start bit so frames stay gapless.
              r_shreg <= w_head;
              r_par   <= ^w_head;
              r_tx    <= 1'b0;
              r_state <= S_START;
            end else begin
              r_tx    <= 1'b1;
              r_state <= S_IDLE;
            end
          end else begin
            r_baud <= r_baud - 16'd1;
          end
        end

        default: begin
          r_tx    <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three configurations checked cycle by cycle against a frame-level line model.
module tb_uart_tx_fifo;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       req   [3];
  logic [7:0] wdata [3];
  logic       tx    [3];
  logic       busy  [3];
  logic       ack   [3];
  logic [2:0] cnt0;
  logic [2:0] cnt1;
  logic [3:0] cnt2;
  logic [3:0] cnt   [3];

  assign cnt[0] = {1'b0, cnt0};
  assign cnt[1] = {1'b0, cnt1};
  assign cnt[2] = cnt2;

  int cyc    = 0;
  int n_pass = 0;
  int n_total = 0;

  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_fifo #(.CLK_DIV(4), .FIFO_DEPTH(4), .PARITY(0), .STOP_BITS(1)) u_dut0 (
    .clk_i(clk), .arst_n_i(rst_n), .wr_req_i(req[0]), .wr_data_i(wdata[0]),
    .wr_ack_o(ack[0]), .tx_o(tx[0]), .busy_o(busy[0]), .fifo_cnt_o(cnt0));

  uart_tx_fifo #(.CLK_DIV(4), .FIFO_DEPTH(4), .PARITY(2), .STOP_BITS(2)) u_dut1 (
    .clk_i(clk), .arst_n_i(rst_n), .wr_req_i(req[1]), .wr_data_i(wdata[1]),
    .wr_ack_o(ack[1]), .tx_o(tx[1]), .busy_o(busy[1]), .fifo_cnt_o(cnt1));

  uart_tx_fifo #(.CLK_DIV(3), .FIFO_DEPTH(8), .PARITY(1), .STOP_BITS(1)) u_dut2 (
    .clk_i(clk), .arst_n_i(rst_n), .wr_req_i(req[2]), .wr_data_i(wdata[2]),
    .wr_ack_o(ack[2]), .tx_o(tx[2]), .busy_o(busy[2]), .fifo_cnt_o(cnt2));

  function automatic int cd(int d);  return (d == 2) ? 3 : 4; endfunction
  function automatic int dep(int d); return (d == 2) ? 8 : 4; endfunction
  function automatic int par(int d); return (d == 0) ? 0 : ((d == 1) ? 2 : 1); endfunction
  function automatic int sb(int d);  return (d == 1) ? 2 : 1; endfunction

  // Model: accepted bytes in a queue; the line is a list of per-cycle levels for the current frame.
  logic [7:0] mq     [3][256];
  int         mrd    [3];
  int         mwr    [3];
  int         mcnt   [3];
  bit         fr_lv  [3][64];
  int         fr_pos [3];
  int         fr_len [3];

  function automatic logic [6:0] exp_vec(int d);
    logic act;
    act = fr_pos[d] < fr_len[d];
    return {act ? logic'(fr_lv[d][fr_pos[d]]) : 1'b1, act || (mcnt[d] != 0),
            mcnt[d] < dep(d), 4'(mcnt[d])};
  endfunction

  initial begin : model
    int         pre;
    int         ns;
    bit         acc;
    bit         pop;
    logic [7:0] b;
    bit         sym [12];
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int d = 0; d < 3; d++) begin
          mrd[d] = 0; mwr[d] = 0; mcnt[d] = 0; fr_pos[d] = 0; fr_len[d] = 0;
        end
      end else begin
        for (int d = 0; d < 3; d++) begin
          pre = mcnt[d];
          acc = req[d] && (pre < dep(d));
          pop = 0;
          if (fr_pos[d] < fr_len[d]) fr_pos[d] = fr_pos[d] + 1;
          if (fr_pos[d] >= fr_len[d] && pre > 0) begin
            pop = 1;
            b = mq[d][mrd[d]];
            mrd[d] = (mrd[d] + 1) % 256;
            sym[0] = 0;
            for (int i = 0; i < 8; i++) sym[1 + i] = b[i];
            ns = 9;
            if (par(d) == 1) begin sym[9] = ^b;  ns = 10; end
            if (par(d) == 2) begin sym[9] = ~^b; ns = 10; end
            for (int s = 0; s < sb(d); s++) begin sym[ns] = 1; ns = ns + 1; end
            for (int i = 0; i < ns * cd(d); i++) fr_lv[d][i] = sym[i / cd(d)];
            fr_len[d] = ns * cd(d);
            fr_pos[d] = 0;
          end
          if (acc) begin
            mq[d][mwr[d]] = wdata[d];
            mwr[d] = (mwr[d] + 1) % 256;
          end
          mcnt[d] = pre - int'(pop) + int'(acc);
        end
      end
    end
  end

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      n_total++;
      if ({tx[d], busy[d], ack[d], cnt[d]} !== 7'b1010000)
        $display("FAIL reset dut%0d: tx,busy,ack,cnt got %b want 1010000", d,
                 {tx[d], busy[d], ack[d], cnt[d]});
      else n_pass++;
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single_byte;
    int k, fall, idle;
    @(negedge clk);
    k = cyc + 1; req[0] = 1'b1; wdata[0] = 8'hA5;
    fall = -1; idle = -1;
    for (int i = 0; i < 46; i++) begin
      @(negedge clk);
      n_total++;
      if ({tx[0], busy[0], ack[0], cnt[0]} !== exp_vec(0))
        $display("FAIL single_byte cyc %0d: tx,busy,ack,cnt got %b want %b", cyc,
                 {tx[0], busy[0], ack[0], cnt[0]}, exp_vec(0));
      else n_pass++;
      if (fall < 0 && tx[0] == 1'b0) fall = cyc;
      if (idle < 0 && fall >= 0 && !busy[0]) idle = cyc;
      req[0] = 1'b0;
    end
    n_total++;
    if (fall !== k + 1) $display("FAIL single_fall: got edge %0d want %0d", fall, k + 1);
    else n_pass++;
    n_total++;
    if (idle !== k + 41) $display("FAIL single_idle: got edge %0d want %0d", idle, k + 41);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic [7:0] bytes [3];
    int falls [3];
    int nf;
    logic prev;
    bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h55;
    nf = 0; prev = 1'b1;
    @(negedge clk);
    req[0] = 1'b1; wdata[0] = bytes[0];
    for (int i = 0; i < 125; i++) begin
      @(negedge clk);
      n_total++;
      if ({tx[0], busy[0], ack[0], cnt[0]} !== exp_vec(0))
        $display("FAIL back_to_back cyc %0d: tx,busy,ack,cnt got %b want %b", cyc,
                 {tx[0], busy[0], ack[0], cnt[0]}, exp_vec(0));
      else n_pass++;
      if (prev && !tx[0] && nf < 3) begin falls[nf] = cyc; nf++; end
      prev = tx[0];
      if (i < 2) begin req[0] = 1'b1; wdata[0] = bytes[i + 1]; end
      else req[0] = 1'b0;
    end
    n_total++;
    if (nf < 3 || falls[1] - falls[0] != 40 || falls[2] - falls[1] != 40)
      $display("FAIL back_to_back_gap: got %0d starts, spacing %0d/%0d want 3 starts, 40/40",
               nf, falls[1] - falls[0], falls[2] - falls[1]);
    else n_pass++;
  endtask

  task automatic test_fifo_full;
    int acc_n;
    acc_n = 0;
    @(negedge clk);
    req[0] = 1'b1; wdata[0] = 8'($urandom);
    for (int i = 0; i < 215; i++) begin
      @(negedge clk);
      n_total++;
      if ({tx[0], busy[0], ack[0], cnt[0]} !== exp_vec(0))
        $display("FAIL fifo_full cyc %0d: tx,busy,ack,cnt got %b want %b", cyc,
                 {tx[0], busy[0], ack[0], cnt[0]}, exp_vec(0));
      else n_pass++;
      req[0] = (i >= 1 && i <= 8);
      wdata[0] = 8'($urandom);
      if (req[0] && ack[0]) acc_n++;
    end
    n_total++;
    if (acc_n != 4) $display("FAIL fifo_full_accepts: got %0d want 4", acc_n);
    else n_pass++;
  endtask

  task automatic test_parity_stop;
    int fall, idle;
    logic par_bit;
    fall = -1; idle = -1; par_bit = 1'bx;
    @(negedge clk);
    req[1] = 1'b1; wdata[1] = 8'h07;
    for (int i = 0; i < 55; i++) begin
      @(negedge clk);
      n_total++;
      if ({tx[1], busy[1], ack[1], cnt[1]} !== exp_vec(1))
        $display("FAIL parity_stop cyc %0d: tx,busy,ack,cnt got %b want %b", cyc,
                 {tx[1], busy[1], ack[1], cnt[1]}, exp_vec(1));
      else n_pass++;
      if (fall < 0 && tx[1] == 1'b0) fall = cyc;
      if (fall >= 0 && cyc == fall + 37) par_bit = tx[1];
      if (idle < 0 && fall >= 0 && !busy[1]) idle = cyc;
      req[1] = 1'b0;
    end
    n_total++;
    if (par_bit !== 1'b0) $display("FAIL odd_parity_bit: got %b want 0", par_bit);
    else n_pass++;
    n_total++;
    if (fall < 0 || idle - fall != 48)
      $display("FAIL frame_len_2stop: got %0d want 48", idle - fall);
    else n_pass++;
  endtask

  task automatic test_random;
    for (int i = 0; i < 1400; i++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        n_total++;
        if ({tx[d], busy[d], ack[d], cnt[d]} !== exp_vec(d))
          $display("FAIL random dut%0d cyc %0d: tx,busy,ack,cnt got %b want %b", d, cyc,
                   {tx[d], busy[d], ack[d], cnt[d]}, exp_vec(d));
        else n_pass++;
        if (i < 450)      req[d] = ($urandom_range(0, 3) != 0);
        else if (i < 900) req[d] = ($urandom_range(0, 9) < 2);
        else              req[d] = 1'b0;
        wdata[d] = 8'($urandom);
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    int k;
    @(negedge clk);
    k = cyc + 1;
    req[0] = 1'b1; wdata[0] = 8'($urandom);
    @(negedge clk); wdata[0] = 8'($urandom);
    @(negedge clk); wdata[0] = 8'($urandom);
    @(negedge clk); req[0] = 1'b0;
    while (cyc < k + 19) @(negedge clk);
    n_total++;
    if ({tx[0], busy[0], ack[0], cnt[0]} !== exp_vec(0) || cnt[0] !== 4'd2)
      $display("FAIL pre_reset: tx,busy,ack,cnt got %b want %b with cnt 2",
               {tx[0], busy[0], ack[0], cnt[0]}, exp_vec(0));
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({tx[0], busy[0], ack[0], cnt[0]} !== 7'b1010000)
      $display("FAIL async_reset: tx,busy,ack,cnt got %b want 1010000",
               {tx[0], busy[0], ack[0], cnt[0]});
    else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      n_total++;
      if ({tx[0], busy[0], cnt[0]} !== 6'b100000)
        $display("FAIL after_reset cyc %0d: tx,busy,cnt got %b want 100000", cyc,
                 {tx[0], busy[0], cnt[0]});
      else n_pass++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 3; d++) begin
      req[d] = 1'b0;
      wdata[d] = 8'h00;
    end
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_fifo_full();
    test_parity_stop();
    test_random();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
